// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, derivation helpers and pixel colour type
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CLK_DIV   = 4;

    function automatic int span_total(int disp, int fp, int sync, int bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int sync_start(int disp, int fp);
        return disp + fp;
    endfunction

    function automatic int sync_end(int disp, int fp, int sync);
        return disp + fp + sync - 1;
    endfunction

    localparam int H_TOTAL  = span_total(DEF_H_DISPLAY, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL  = span_total(DEF_V_DISPLAY, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int HS_START = sync_start(DEF_H_DISPLAY, DEF_H_FP);
    localparam int HS_END   = sync_end(DEF_H_DISPLAY, DEF_H_FP, DEF_H_SYNC);
    localparam int VS_START = sync_start(DEF_V_DISPLAY, DEF_V_FP);
    localparam int VS_END   = sync_end(DEF_V_DISPLAY, DEF_V_FP, DEF_V_SYNC);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - pixel-generator side and VGA connector side signals of the timing controller
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    rgb_t             rgb_in;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             p_tick;
    logic             line_start;
    logic             frame_start;
    logic             Hsync;
    logic             Vsync;
    logic [3:0]       vgaRed;
    logic [3:0]       vgaGreen;
    logic [3:0]       vgaBlue;
    logic             video_on;

    modport master (
        input  rgb_in,
        output pixel_x, pixel_y, p_tick, line_start, frame_start,
        output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, video_on
    );

    modport slave (
        output rgb_in,
        input  pixel_x, pixel_y, p_tick, line_start, frame_start,
        input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, video_on
    );

endinterface

// File: rtl/vga_tick_div.sv
// rtl/vga_tick_div.sv - clock-enable divider producing one p_tick every CLK_DIV clk cycles
module vga_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Tick is decoded from the count so it is high for the whole last cycle of each slot.
    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - 640x480@60 VGA raster counters with a one-tick registered sync/colour stage
module vga_timing_ctrl import vga_pkg::*; #(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_timing_ctrl_if.master vif
);

    localparam logic [CNT_W-1:0] H_DISP_C = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP_C = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(span_total(H_DISPLAY, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(span_total(V_DISPLAY, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(sync_start(H_DISPLAY, H_FP));
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(sync_end(H_DISPLAY, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(sync_start(V_DISPLAY, V_FP));
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(sync_end(V_DISPLAY, V_FP, V_SYNC));

    logic             p_tick;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    rgb_t             rgb_q, rgb_d;
    logic             visible;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (p_tick)
    );

    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        rgb_d      = rgb_q;
        visible    = (h_cnt_q < H_DISP_C) && (v_cnt_q < V_DISP_C);

        if (p_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end

            // All outputs are captured from the same counter snapshot so they stay mutually aligned.
            hsync_d    = !((h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C));
            vsync_d    = !((v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C));
            video_on_d = visible;
            rgb_d      = visible ? vif.rgb_in : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign vif.pixel_x     = h_cnt_q;
    assign vif.pixel_y     = v_cnt_q;
    assign vif.p_tick      = p_tick;
    assign vif.line_start  = p_tick && (h_cnt_q == '0);
    assign vif.frame_start = p_tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign vif.Hsync       = hsync_q;
    assign vif.Vsync       = vsync_q;
    assign vif.video_on    = video_on_q;
    assign vif.vgaRed      = rgb_q.r;
    assign vif.vgaGreen    = rgb_q.g;
    assign vif.vgaBlue     = rgb_q.b;

endmodule
